// File: rtl/arb_pkg.sv
// Shared types for the arbiter FIFO read side: entry layout, mode encoding,
// unpacker FSM states and the lanes-per-mode helper.
package arb_pkg;

   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned ARB_MASK_W = 8;
   localparam int unsigned ARB_FIFO_W = 43;

   typedef enum logic [1:0] {
      MODE_ILLEGAL = 2'b00,
      MODE_16      = 2'b01,
      MODE_8       = 2'b10,
      MODE_32      = 2'b11
   } arb_mode_t;

   typedef struct packed {
      logic                  src;
      arb_mode_t             mode;
      logic [ARB_MASK_W-1:0] proc_valid;
      logic [ARB_DATA_W-1:0] data;
   } arb_fifo_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EMIT
   } unpack_state_t;

   function automatic logic [2:0] lanes_of(input arb_mode_t mode);
      case (mode)
         MODE_8:  lanes_of = 3'd4;
         MODE_16: lanes_of = 3'd2;
         MODE_32: lanes_of = 3'd1;
         default: lanes_of = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/arb_lane_sel.sv
// Holding register for one popped FIFO entry plus the lane multiplexer that
// slices the held word into LSB-first lanes according to its mode.
module arb_lane_sel
   import arb_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [ARB_FIFO_W-1:0] entry_i,
   input  logic [1:0]            lane_i,
   output logic [ARB_DATA_W-1:0] data_o,
   output logic                  last_o,
   output logic [1:0]            mode_o,
   output logic [ARB_MASK_W-1:0] mask_o,
   output logic                  src_o
);

   arb_fifo_entry_t hold_q;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q <= '0;
      end else if (load_i) begin
         hold_q <= arb_fifo_entry_t'(entry_i);
      end
   end

   always_comb begin
      byte_sel = '0;
      case (lane_i)
         2'd0:    byte_sel = hold_q.data[7:0];
         2'd1:    byte_sel = hold_q.data[15:8];
         2'd2:    byte_sel = hold_q.data[23:16];
         default: byte_sel = hold_q.data[31:24];
      endcase
      half_sel = lane_i[0] ? hold_q.data[31:16] : hold_q.data[15:0];

      data_o = '0;
      case (hold_q.mode)
         MODE_8:  data_o = {24'd0, byte_sel};
         MODE_16: data_o = {16'd0, half_sel};
         MODE_32: data_o = hold_q.data;
         default: data_o = '0;
      endcase
   end

   // An illegal mode yields lanes-1 = 7, which a 2-bit lane index never reaches.
   assign last_o = ({1'b0, lane_i} == (lanes_of(hold_q.mode) - 3'd1));
   assign mode_o = hold_q.mode;
   assign mask_o = hold_q.proc_valid;
   assign src_o  = hold_q.src;

endmodule

// File: rtl/arb_fifo_unpacker.sv
// Pops arbiter FIFO entries and streams them out as lane-serial pixels, pulsing
// mstr0_cmplt per burst. Define ARB_UNPACK_PREFETCH_EN to pop on the last lane.
module arb_fifo_unpacker
   import arb_pkg::*;
#(
   parameter int unsigned DATA_W    = ARB_DATA_W,
   parameter int unsigned MASK_W    = ARB_MASK_W,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [ARB_FIFO_W-1:0] fifo_rd_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [DATA_W-1:0]     pix_data,
   output logic [1:0]            pix_mode,
   output logic [MASK_W-1:0]     pix_mask,
   output logic                  pix_src,
   output logic                  pix_last,
   output logic                  mstr0_cmplt,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

   unpack_state_t        state_q, state_d;
   logic [1:0]           lane_q, lane_d;
   logic [15:0]          wcnt_q, wcnt_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 cmplt_q, cmplt_d;
   logic                 rd_en;
   logic                 load;
   logic                 sel_last;
   arb_mode_t            rd_mode;

   assign rd_mode = arb_mode_t'(fifo_rd_data[ARB_FIFO_W-2 -: 2]);

   arb_lane_sel u_lane_sel (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .load_i  (load),
      .entry_i (fifo_rd_data),
      .lane_i  (lane_q),
      .data_o  (pix_data),
      .last_o  (sel_last),
      .mode_o  (pix_mode),
      .mask_o  (pix_mask),
      .src_o   (pix_src)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lane_q  <= '0;
         wcnt_q  <= '0;
         err_q   <= '0;
         cmplt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         cmplt_q <= cmplt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      cmplt_d = 1'b0;
      rd_en   = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               rd_en   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            load   = 1'b1;
            lane_d = '0;
            if (rd_mode == MODE_ILLEGAL) begin
               if (err_q != '1) begin
                  err_d = err_q + ERR_CNT_W'(1);
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (pix_ready) begin
               if (sel_last) begin
                  if (wcnt_q == BURST_LAST) begin
                     wcnt_d  = '0;
                     cmplt_d = 1'b1;
                  end else begin
                     wcnt_d = wcnt_q + 16'd1;
                  end
                  state_d = ST_IDLE;
`ifdef ARB_UNPACK_PREFETCH_EN
                  if (!fifo_empty) begin
                     rd_en   = 1'b1;
                     state_d = ST_FETCH;
                  end
`endif
               end else begin
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gated so the pop request is also low while reset is held.
   assign fifo_rd_en  = rd_en & rst_n;
   assign pix_valid   = (state_q == ST_EMIT);
   assign pix_last    = (state_q == ST_EMIT) & sel_last;
   assign mstr0_cmplt = cmplt_q;
   assign err_cnt     = err_q;

endmodule

// File: tb/tb_arb_fifo_unpacker.sv
// Directed bench for arb_fifo_unpacker: a table of single-word vectors plus
// hand-written backpressure, saturation, mid-word reset and burst sequences.
module tb_arb_fifo_unpacker;
   import arb_pkg::*;

   localparam int unsigned BL = 4;
`ifdef ARB_UNPACK_PREFETCH_EN
   localparam int B2B = 2;
`else
   localparam int B2B = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [42:0] fifo_rd_data = '0;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] pix_data;
   logic [1:0]  pix_mode;
   logic [7:0]  pix_mask;
   logic        pix_src;
   logic        pix_last;
   logic        mstr0_cmplt;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   arb_fifo_unpacker #(.BURST_LEN(BL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_data     (pix_data),
      .pix_mode     (pix_mode),
      .pix_mask     (pix_mask),
      .pix_src      (pix_src),
      .pix_last     (pix_last),
      .mstr0_cmplt  (mstr0_cmplt),
      .err_cnt      (err_cnt)
   );

   // FIFO model: pushes come from the stimulus process, pops return data one cycle later.
   logic [42:0] mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int underflow = 0;
   int cyc = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         if (wr_ptr == rd_ptr) underflow <= underflow + 1;
         else begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
         end
      end
   end

   typedef struct {
      int          c;
      logic [31:0] data;
      logic        last;
      logic [1:0]  mode;
      logic [7:0]  mask;
      logic        src;
   } hs_t;

   hs_t hs_log[$];
   int  rd_log[$];
   int  cm_log[$];

   always @(negedge clk) begin
      if (pix_valid && pix_ready)
         hs_log.push_back(hs_t'{cyc, pix_data, pix_last, pix_mode, pix_mask, pix_src});
      if (fifo_rd_en) rd_log.push_back(cyc);
      if (mstr0_cmplt) cm_log.push_back(cyc);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [42:0] e);
      mem[wr_ptr] = e;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
      chk({tag, "_valid"}, 32'(pix_valid), 0);
      chk({tag, "_data"},  pix_data, 0);
      chk({tag, "_mode"},  32'(pix_mode), 0);
      chk({tag, "_mask"},  32'(pix_mask), 0);
      chk({tag, "_src"},   32'(pix_src), 0);
      chk({tag, "_last"},  32'(pix_last), 0);
      chk({tag, "_cmplt"}, 32'(mstr0_cmplt), 0);
      chk({tag, "_err"},   32'(err_cnt), 0);
   endtask

   // lane field is packed: lane[0] (rightmost) is the first lane out.
   typedef struct {
      logic [42:0]      entry;
      int               nl;
      logic [3:0][31:0] lane;
      logic [7:0]       err;
      logic             cm;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int h0, r0, m0, w;
      logic [42:0] e;

      vecs[0] = '{{1'b0, 2'b10, 8'hFF, 32'h2DAAD83D}, 4,
                  {32'h2D, 32'hAA, 32'hD8, 32'h3D}, 8'd0, 1'b0};
      vecs[1] = '{{1'b1, 2'b01, 8'h0F, 32'hF9B550E1}, 2,
                  {32'h0, 32'h0, 32'hF9B5, 32'h50E1}, 8'd0, 1'b0};
      vecs[2] = '{{1'b0, 2'b11, 8'hA5, 32'hA87EAF30}, 1,
                  {32'h0, 32'h0, 32'h0, 32'hA87EAF30}, 8'd0, 1'b0};
      vecs[3] = '{{1'b1, 2'b00, 8'h33, 32'h12345678}, 0, '0, 8'd1, 1'b0};
      vecs[4] = '{{1'b0, 2'b00, 8'hC3, 32'hDEADBEEF}, 0, '0, 8'd2, 1'b0};
      vecs[5] = '{{1'b1, 2'b00, 8'h01, 32'hCAFEF00D}, 0, '0, 8'd3, 1'b0};
      vecs[6] = '{{1'b1, 2'b10, 8'h81, 32'h01020304}, 4,
                  {32'h01, 32'h02, 32'h03, 32'h04}, 8'd3, 1'b1};

      rst_n     = 1'b0;
      pix_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk_all_zero("rst_hold");
      step();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk_all_zero("rst_rel");
      step();

      // Vector table: one word at a time with pix_ready held high.
      for (int i = 0; i < 7; i++) begin
         h0 = hs_log.size();
         r0 = rd_log.size();
         m0 = cm_log.size();
         push(vecs[i].entry);
         repeat (vecs[i].nl + 5) step();
         chk($sformatf("v%0d_pops", i), rd_log.size() - r0, 1);
         chk($sformatf("v%0d_lanes", i), hs_log.size() - h0, vecs[i].nl);
         if (rd_log.size() == r0 + 1 && hs_log.size() == h0 + vecs[i].nl) begin
            for (int j = 0; j < vecs[i].nl; j++) begin
               if (j == 0) chk($sformatf("v%0d_latency", i), hs_log[h0].c, rd_log[r0] + 2);
               chk($sformatf("v%0d_l%0d_data", i, j), hs_log[h0+j].data, vecs[i].lane[j]);
               chk($sformatf("v%0d_l%0d_last", i, j), 32'(hs_log[h0+j].last),
                   32'(j == vecs[i].nl - 1));
               chk($sformatf("v%0d_l%0d_mode", i, j), 32'(hs_log[h0+j].mode), 32'(vecs[i].entry[41:40]));
               chk($sformatf("v%0d_l%0d_mask", i, j), 32'(hs_log[h0+j].mask), 32'(vecs[i].entry[39:32]));
               chk($sformatf("v%0d_l%0d_src", i, j), 32'(hs_log[h0+j].src), 32'(vecs[i].entry[42]));
            end
         end
         chk($sformatf("v%0d_err", i), 32'(err_cnt), 32'(vecs[i].err));
         chk($sformatf("v%0d_cmplt_n", i), cm_log.size() - m0, 32'(vecs[i].cm));
         if (vecs[i].cm && cm_log.size() > m0 && hs_log.size() > h0)
            chk($sformatf("v%0d_cmplt_cyc", i), cm_log[m0], hs_log[hs_log.size()-1].c + 1);
      end

      // Backpressure: lane 2 (0x57) held for three cycles of pix_ready=0.
      h0 = hs_log.size();
      r0 = rd_log.size();
      m0 = cm_log.size();
      push({1'b0, 2'b10, 8'h3C, 32'h8F57C788});
      for (int k = 1; k <= 9; k++) begin
         step();
         pix_ready = !(k >= 4 && k <= 6);
         @(negedge clk);
         if (k >= 4 && k <= 7) begin
            chk($sformatf("bp_k%0d_valid", k), 32'(pix_valid), 1);
            chk($sformatf("bp_k%0d_data", k), pix_data, 32'h57);
            chk($sformatf("bp_k%0d_last", k), 32'(pix_last), 0);
            chk($sformatf("bp_k%0d_mask", k), 32'(pix_mask), 32'h3C);
         end
      end
      pix_ready = 1'b1;
      chk("bp_pops", rd_log.size() - r0, 1);
      chk("bp_lanes", hs_log.size() - h0, 4);
      chk("bp_cmplt_n", cm_log.size() - m0, 0);
      if (rd_log.size() == r0 + 1 && hs_log.size() == h0 + 4) begin
         chk("bp_l2_cyc", hs_log[h0+2].c, rd_log[r0] + 7);
         chk("bp_l3_data", hs_log[h0+3].data, 32'h8F);
         chk("bp_l3_last", 32'(hs_log[h0+3].last), 1);
         chk("bp_l3_cyc", hs_log[h0+3].c, rd_log[r0] + 8);
      end
      step();

      // Error counter saturation: 3 + 260 illegal words must stop at FF.
      h0 = hs_log.size();
      for (int k = 0; k < 260; k++) push({1'b0, 2'b00, 8'h00, 32'(k)});
      w = 0;
      while (wr_ptr != rd_ptr && w < 2000) begin
         step();
         w++;
      end
      chk("sat_drained", 32'(wr_ptr == rd_ptr), 1);
      repeat (4) step();
      @(negedge clk);
      chk("sat_err", 32'(err_cnt), 32'hFF);
      chk("sat_lanes", hs_log.size() - h0, 0);
      step();

      // Reset while lane 1 is on the bus.
      h0 = hs_log.size();
      r0 = rd_log.size();
      push({1'b1, 2'b10, 8'h5A, 32'h11223344});
      repeat (3) step();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_lane1_data", pix_data, 32'h33);
      step();
      @(negedge clk);
      chk_all_zero("mr_rst");
      step();
      rst_n = 1'b1;
      step();
      push({1'b0, 2'b11, 8'h77, 32'hCAFE1234});
      repeat (6) step();
      chk("mr_pops", rd_log.size() - r0, 2);
      chk("mr_lanes", hs_log.size() - h0, 3);
      if (rd_log.size() == r0 + 2 && hs_log.size() == h0 + 3) begin
         chk("mr_new_data", hs_log[h0+2].data, 32'hCAFE1234);
         chk("mr_new_cyc", hs_log[h0+2].c, rd_log[r0+1] + 2);
      end
      chk("mr_err", 32'(err_cnt), 0);

      // Burst of BL legal words with illegal words interleaved.
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      h0 = hs_log.size();
      m0 = cm_log.size();
      for (int k = 0; k < 7; k++) begin
         e = (k == 1 || k == 3) ? {1'b0, 2'b00, 8'h00, 32'hBAD0 + 32'(k)}
                                : {1'b1, 2'b11, 8'hF0, 32'hB0B0_0000 + 32'(k)};
         push(e);
      end
      repeat (40) step();
      chk("bu_lanes", hs_log.size() - h0, 5);
      chk("bu_cmplt_n", cm_log.size() - m0, 1);
      chk("bu_err", 32'(err_cnt), 2);
      if (hs_log.size() == h0 + 5) begin
         chk("bu_w3_data", hs_log[h0+3].data, 32'hB0B0_0005);
         chk("bu_w4_data", hs_log[h0+4].data, 32'hB0B0_0006);
         chk("bu_b2b_a", hs_log[h0+3].c - hs_log[h0+2].c, B2B);
         chk("bu_b2b_b", hs_log[h0+4].c - hs_log[h0+3].c, B2B);
         if (cm_log.size() > m0) chk("bu_cmplt_cyc", cm_log[m0], hs_log[h0+3].c + 1);
      end

      chk("no_underflow", underflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
